// File: rtl/fifo_interleave_pkg.sv
// rtl/fifo_interleave_pkg.sv - width helpers and parameter checks for the interleaved FIFO
package fifo_interleave_pkg;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << r) < 64'(v)) r = r + 1;
      end
      return r;
   endfunction

   // Pointers are never narrower than one bit so single-entry cases still elaborate.
   function automatic int ptr_w(input int n);
      return (n <= 1) ? 1 : clog2(n);
   endfunction

   function automatic int cnt_w(input int lanes, input int depth);
      return clog2(lanes * depth + 1);
   endfunction

   function automatic bit params_ok(input int width, input int lanes, input int depth);
      return (width >= 1) && (lanes >= 2) && (lanes <= 16) && (depth >= 1) && (depth <= 16);
   endfunction

endpackage

// File: rtl/fifo_lane.sv
// rtl/fifo_lane.sv - single-lane circular buffer with full/empty flags
module fifo_lane
   import fifo_interleave_pkg::*;
#(
   parameter int WIDTH = 704,
   parameter int DEPTH = 1
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             flush_i,
   input  logic             enq_i,
   input  logic [WIDTH-1:0] enq_data_i,
   input  logic             deq_i,
   output logic [WIDTH-1:0] first_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = ptr_w(DEPTH);
   localparam int OW = clog2(DEPTH + 1);

   // Storage is rounded up to a power of two so the pointer always indexes in range.
   logic [WIDTH-1:0] mem_q [0:(1<<AW)-1];
   logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [OW-1:0]    occ_q, occ_d;

   function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      if (flush_i) begin
         head_d = '0;
         tail_d = '0;
         occ_d  = '0;
      end else begin
         if (enq_i) tail_d = bump(tail_q);
         if (deq_i) head_d = bump(head_q);
         if (enq_i && !deq_i) occ_d = occ_q + 1'b1;
         else if (deq_i && !enq_i) occ_d = occ_q - 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (enq_i && !flush_i) mem_q[tail_q] <= enq_data_i;
   end

   assign first_o = mem_q[head_q];
   assign full_o  = (occ_q == OW'(DEPTH));
   assign empty_o = (occ_q == '0);

endmodule

// File: rtl/fifo_interleave_n.sv
// rtl/fifo_interleave_n.sv - strict-order FIFO striped round-robin across LANES lanes
module fifo_interleave_n
   import fifo_interleave_pkg::*;
#(
   parameter int WIDTH = 704,
   parameter int LANES = 2,
   parameter int DEPTH = 1
) (
   input  logic                              CLK,
   input  logic                              nRST,
   input  logic                              in_enq__ENA,
   input  logic [WIDTH-1:0]                  in_enq_v,
   output logic                              in_enq__RDY,
   input  logic                              out_deq__ENA,
   output logic                              out_deq__RDY,
   output logic [WIDTH-1:0]                  out_first,
   output logic                              out_first__RDY,
   input  logic                              flush,
   output logic [cnt_w(LANES, DEPTH)-1:0]    count
);

   localparam int PW = ptr_w(LANES);
   localparam int CW = cnt_w(LANES, DEPTH);

   if (!params_ok(WIDTH, LANES, DEPTH)) begin : g_bad_params
      $error("fifo_interleave_n: WIDTH/LANES/DEPTH out of range");
   end

   logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0]    count_q, count_d;
   logic [LANES-1:0] lane_full, lane_empty, lane_enq, lane_deq;
   logic [LANES-1:0] wp_oh, rp_oh;
   logic [WIDTH-1:0] lane_first [LANES];
   logic             enq_rdy, deq_rdy, enq_fire, deq_fire;
   logic [WIDTH-1:0] first_mux;

   always_comb begin
      wp_oh     = '0;
      rp_oh     = '0;
      enq_rdy   = 1'b0;
      deq_rdy   = 1'b0;
      first_mux = '0;
      for (int i = 0; i < LANES; i++) begin
         if (wp_q == PW'(i)) begin
            wp_oh[i] = 1'b1;
            enq_rdy  = !lane_full[i];
         end
         if (rp_q == PW'(i)) begin
            rp_oh[i]  = 1'b1;
            deq_rdy   = !lane_empty[i];
            first_mux = lane_first[i];
         end
      end
   end

   // Flush discards any same-cycle traffic, so it gates both fire terms.
   assign enq_fire = in_enq__ENA && enq_rdy && !flush;
   assign deq_fire = out_deq__ENA && deq_rdy && !flush;
   assign lane_enq = wp_oh & {LANES{enq_fire}};
   assign lane_deq = rp_oh & {LANES{deq_fire}};

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      fifo_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane (
         .CLK        (CLK),
         .nRST       (nRST),
         .flush_i    (flush),
         .enq_i      (lane_enq[g]),
         .enq_data_i (in_enq_v),
         .deq_i      (lane_deq[g]),
         .first_o    (lane_first[g]),
         .full_o     (lane_full[g]),
         .empty_o    (lane_empty[g])
      );
   end

   always_comb begin
      wp_d    = wp_q;
      rp_d    = rp_q;
      count_d = count_q;
      if (flush) begin
         wp_d    = '0;
         rp_d    = '0;
         count_d = '0;
      end else begin
         if (enq_fire) wp_d = (wp_q == PW'(LANES - 1)) ? '0 : wp_q + 1'b1;
         if (deq_fire) rp_d = (rp_q == PW'(LANES - 1)) ? '0 : rp_q + 1'b1;
         if (enq_fire && !deq_fire) count_d = count_q + 1'b1;
         else if (deq_fire && !enq_fire) count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
      end
   end

   assign in_enq__RDY    = enq_rdy;
   assign out_deq__RDY   = deq_rdy;
   assign out_first__RDY = deq_rdy;
   assign out_first      = first_mux;
   assign count          = count_q;

endmodule

// File: doc/fifo_interleave_n.md
FIFO_INTERLEAVE_N -- requirements
Module: fifo_interleave_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 704: data payload width in bits, 1 or more.
REQ-002 The block SHALL have parameter LANES, default 2: number of interleaved lanes, 2..16.
REQ-003 The block SHALL have parameter DEPTH, default 1: entries per lane, 1..16.
REQ-004 The block SHALL have port CLK, input, 1 bit: clock; all state updates on posedge.
REQ-005 The block SHALL have port nRST, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port in_enq__ENA, input, 1 bit: enqueue request.
REQ-007 The block SHALL have port in_enq_v, input, WIDTH bits: enqueue data.
REQ-008 The block SHALL have port in_enq__RDY, output, 1 bit: lane at enqueue pointer not full.
REQ-009 The block SHALL have port out_deq__ENA, input, 1 bit: dequeue request.
REQ-010 The block SHALL have port out_deq__RDY, output, 1 bit: lane at dequeue pointer not empty.
REQ-011 The block SHALL have port out_first, output, WIDTH bits: head of the lane at the dequeue pointer.
REQ-012 The block SHALL have port out_first__RDY, output, 1 bit: equal to out_deq__RDY.
REQ-013 The block SHALL have port flush, input, 1 bit: synchronous clear of all contents.
REQ-014 The block SHALL have port count, output, CW = clog2(LANES*DEPTH+1) bits: total occupancy.

Function
REQ-015 An enqueue SHALL fire only when in_enq__ENA && in_enq__RDY; ENA without RDY SHALL be ignored with no state change.
REQ-016 A dequeue SHALL fire only when out_deq__ENA && out_deq__RDY; ENA without RDY SHALL be ignored.
REQ-017 On an enqueue, in_enq_v SHALL be written to the tail of lane wp, and wp SHALL advance by 1 modulo LANES, wrapping LANES-1 -> 0.
REQ-018 On a dequeue, the head of lane rp SHALL be removed, and rp SHALL advance by 1 modulo LANES.
REQ-019 Global order SHALL be strict FIFO: the k-th dequeued word equals the k-th enqueued word.
REQ-020 Write-to-read latency SHALL be 1 cycle: a word enqueued at edge n is visible on out_first after edge n, with no same-cycle bypass.
REQ-021 Enqueue and dequeue in the same cycle SHALL both fire when both are ready; count SHALL then be unchanged.
REQ-022 count SHALL increment by 1 on an enqueue-only cycle and decrement by 1 on a dequeue-only cycle, saturating neither; it never exceeds LANES*DEPTH by construction.
REQ-023 For LANES>=2, the block SHALL sustain 1 word per cycle in and out concurrently in steady state.
REQ-024 When count = LANES*DEPTH, in_enq__RDY SHALL be 0; when count = 0, out_deq__RDY and out_first__RDY SHALL be 0.
REQ-025 out_first SHALL be don't-care while out_first__RDY = 0, and SHALL be stable while no dequeue fires.
REQ-026 flush=1 SHALL, at the next edge, empty every lane, set wp = rp = 0 and set count = 0; enqueue or dequeue in the same cycle SHALL be discarded.
REQ-027 RDY outputs SHALL be combinational from state only and SHALL NOT depend on ENA inputs.

Reset
REQ-028 While nRST=0 at a posedge, the block SHALL set all lanes empty, wp=0, rp=0 and count=0.
REQ-029 After reset, the outputs SHALL be in_enq__RDY=1, out_deq__RDY=0, out_first__RDY=0, count=0.
REQ-030 Reset mid-operation SHALL discard all stored words, with no partial dequeue.
REQ-031 Reset SHALL take priority over flush, enqueue and dequeue.
REQ-032 Lane data storage SHALL NOT require reset.

Structure
REQ-033 A shared package fifo_interleave_pkg SHALL hold a clog2 helper function, the pointer/count width derivations, and parameter-range assertions.
REQ-034 There SHALL be one sub-module, fifo_lane: a DEPTH-entry circular buffer with enq/deq/first/flush and full/empty flags.
REQ-035 fifo_interleave_n SHALL instantiate LANES copies of fifo_lane via generate.
REQ-036 Per-lane ENA SHALL be the fired enqueue or dequeue ANDed with a one-hot decode of wp or rp.
REQ-037 out_first SHALL be a LANES:1 mux on rp.

Verification
REQ-038 Reset/idle scenario: with LANES=2, DEPTH=1, hold nRST=0 for 2 cycles -> in_enq__RDY=1, out_deq__RDY=0, count=0.
REQ-039 Fill/full scenario: with LANES=2, DEPTH=1, enqueue 0xA then 0xB -> count=2, in_enq__RDY=0; a third ENA is ignored and count stays 2.
REQ-040 Ordering/wrap scenario: with LANES=3, DEPTH=2, enqueue values 1..6, then dequeue 6 times -> out_first sequence is 1,2,3,4,5,6 and count returns to 0; wp and rp have each wrapped twice.
REQ-041 Throughput scenario: with LANES=2, DEPTH=1, enqueue and dequeue every cycle for 100 cycles after 1 prefill -> 100 words out, in order, count constant at 1.
REQ-042 Flush scenario: with 3 words stored, assert flush together with enqueue and dequeue ENA -> next cycle count=0, out_deq__RDY=0, the enqueued word is lost, and the next enqueue lands in lane 0.
REQ-043 Reset mid-stream scenario: with count=2, pulse nRST=0 for 1 cycle -> count=0, in_enq__RDY=1, and the next dequeued word is the first word enqueued after reset.
